// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-transmitter signals of the UART transmit arbiter.
// The arbiter uses the master modport; the requesters and the UART use slave.
interface uart_tx_arbiter_if;
  // Handshake: Req[i] is held high, with Req_Data[8i+7:8i] stable, until a
  // one-cycle Ack[i] pulse. Ack[i] rises together with ld_Tx_Data, when
  // Tx_Data already holds the accepted byte. Grant names the owner for the
  // whole frame. Tx_Empty is the UART's holding-register-empty flag.
  logic [3:0]  Req;
  logic [31:0] Req_Data;
  logic [3:0]  Ack;
  logic [3:0]  Grant;
  logic        ld_Tx_Data;
  logic [7:0]  Tx_Data;
  logic        Tx_Enable;
  logic        Tx_Empty;

  modport master (
    input  Req, Req_Data, Tx_Empty,
    output Ack, Grant, ld_Tx_Data, Tx_Data, Tx_Enable
  );

  modport slave (
    output Req, Req_Data, Tx_Empty,
    input  Ack, Grant, ld_Tx_Data, Tx_Data, Tx_Enable
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from four requesters into a single UART
// transmitter, with load-failure detection, inter-frame gap and frame counting.
module uart_tx_arbiter #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  uart_tx_arbiter_if.master bus,
  output logic              Busy,
  output logic              Load_Err,
  output logic [15:0]       Frame_Count,
  output logic [2:0]        Dbg_State
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  state_t      state, state_n;
  logic [1:0]  last, last_n;
  logic [3:0]  grant, grant_n;
  logic [7:0]  tx_data, tx_data_n;
  logic        load_err, load_err_n;
  logic [15:0] frame_cnt, frame_cnt_n;
  logic [3:0]  gap_cnt, gap_cnt_n;
  logic        wb_seen, wb_seen_n;

  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  cand;

  // Scan from lowest to highest priority so the highest-priority hit is kept.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last;
    cand      = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (bus.Req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      last      <= 2'd3;
      grant     <= 4'd0;
      tx_data   <= 8'h00;
      load_err  <= 1'b0;
      frame_cnt <= 16'h0000;
      gap_cnt   <= 4'd0;
      wb_seen   <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      grant     <= grant_n;
      tx_data   <= tx_data_n;
      load_err  <= load_err_n;
      frame_cnt <= frame_cnt_n;
      gap_cnt   <= gap_cnt_n;
      wb_seen   <= wb_seen_n;
    end
  end

  always_comb begin
    state_n     = state;
    last_n      = last;
    grant_n     = grant;
    tx_data_n   = tx_data;
    load_err_n  = load_err;
    frame_cnt_n = frame_cnt;
    gap_cnt_n   = gap_cnt;
    wb_seen_n   = wb_seen;
    case (state)
      IDLE: begin
        if (Enable && bus.Tx_Empty && win_valid) begin
          state_n   = LOAD;
          last_n    = win_idx;
          grant_n   = 4'b0001 << win_idx;
          tx_data_n = bus.Req_Data[8*win_idx +: 8];
        end
      end
      LOAD: begin
        state_n   = WAIT_BUSY;
        wb_seen_n = 1'b0;
      end
      WAIT_BUSY: begin
        // Two empty samples in a row mean the UART never took the byte.
        if (!bus.Tx_Empty) begin
          state_n = WAIT_DONE;
        end else if (wb_seen) begin
          state_n    = IDLE;
          load_err_n = 1'b1;
          grant_n    = 4'd0;
        end else begin
          wb_seen_n = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.Tx_Empty) begin
          frame_cnt_n = frame_cnt + 16'd1;
          grant_n     = 4'd0;
          gap_cnt_n   = GAP_LOAD;
          state_n     = (GAP_LOAD == 4'd0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt <= 4'd1) begin
          state_n   = IDLE;
          gap_cnt_n = 4'd0;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode flops only, so Req and Tx_Empty never reach them combinationally.
  assign bus.ld_Tx_Data = (state == LOAD);
  assign bus.Ack        = (state == LOAD) ? grant : 4'd0;
  assign bus.Grant      = grant;
  assign bus.Tx_Data    = tx_data;
  assign bus.Tx_Enable  = (state == LOAD) || (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign Busy           = (state != IDLE);
  assign Load_Err       = load_err;
  assign Frame_Count    = frame_cnt;
  assign Dbg_State      = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle-by-cycle vector table plus a
// hand-written round-robin sequence against a responsive UART.
module tb_uart_tx_arbiter;

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic        Busy;
  logic        Load_Err;
  logic [15:0] Frame_Count;
  logic [2:0]  Dbg_State;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.GAP_CYCLES(2)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Enable      (Enable),
    .bus         (bus.master),
    .Busy        (Busy),
    .Load_Err    (Load_Err),
    .Frame_Count (Frame_Count),
    .Dbg_State   (Dbg_State)
  );

  // Clock and watchdog
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] data;
    logic        empty;
    logic [2:0]  st;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        ld;
    logic [7:0]  txd;
    logic        txen;
    logic        busy;
    logic        lerr;
    logic [15:0] fc;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic en, logic [3:0] req, logic [31:0] data,
                              logic empty, logic [2:0] st, logic [3:0] ack,
                              logic [3:0] grant, logic ld, logic [7:0] txd, logic txen,
                              logic busy, logic lerr, logic [15:0] fc);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.data = data; v.empty = empty;
    v.st = st; v.ack = ack; v.grant = grant; v.ld = ld; v.txd = txd;
    v.txen = txen; v.busy = busy; v.lerr = lerr; v.fc = fc;
    return v;
  endfunction

  // Driver: inputs change at the falling edge, outputs checked at the next one.
  task automatic drive(input logic rst, input logic en, input logic [3:0] req,
                       input logic [31:0] data, input logic empty);
    Reset        = rst;
    Enable       = en;
    bus.Req      = req;
    bus.Req_Data = data;
    bus.Tx_Empty = empty;
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  localparam logic [2:0] S_I = 3'd0, S_L = 3'd1, S_WB = 3'd2, S_WD = 3'd3, S_G = 3'd4;

  initial begin
    logic [3:0] exp_ack;
    logic [7:0] exp_txd;
    int n;

    drive(1'b1, 1'b1, 4'd0, 32'd0, 1'b1);

    //            rst en  req      data          emp | st    ack      grant    ld txd   ten bsy le fc
    vecs[0]  = mk(1, 1, 4'b0000, 32'h0000_0000, 1, S_I,  4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0, 16'd0);
    vecs[1]  = mk(0, 1, 4'b0100, 32'h00A5_0000, 1, S_L,  4'b0100, 4'b0100, 1, 8'hA5, 1, 1, 0, 16'd0);
    vecs[2]  = mk(0, 1, 4'b0000, 32'h0000_0000, 1, S_WB, 4'b0000, 4'b0100, 0, 8'hA5, 1, 1, 0, 16'd0);
    vecs[3]  = mk(0, 1, 4'b0000, 32'h0000_0000, 0, S_WD, 4'b0000, 4'b0100, 0, 8'hA5, 1, 1, 0, 16'd0);
    vecs[4]  = mk(0, 1, 4'b0000, 32'h0000_0000, 0, S_WD, 4'b0000, 4'b0100, 0, 8'hA5, 1, 1, 0, 16'd0);
    vecs[5]  = mk(0, 1, 4'b0000, 32'h0000_0000, 1, S_G,  4'b0000, 4'b0000, 0, 8'hA5, 0, 1, 0, 16'd1);
    vecs[6]  = mk(0, 1, 4'b0001, 32'h0000_005A, 1, S_G,  4'b0000, 4'b0000, 0, 8'hA5, 0, 1, 0, 16'd1);
    vecs[7]  = mk(0, 1, 4'b0001, 32'h0000_005A, 1, S_I,  4'b0000, 4'b0000, 0, 8'hA5, 0, 0, 0, 16'd1);
    vecs[8]  = mk(0, 1, 4'b0001, 32'h0000_005A, 1, S_L,  4'b0001, 4'b0001, 1, 8'h5A, 1, 1, 0, 16'd1);
    // Stuck UART: Tx_Empty never drops after the load
    vecs[9]  = mk(0, 1, 4'b0000, 32'h0000_0000, 1, S_WB, 4'b0000, 4'b0001, 0, 8'h5A, 1, 1, 0, 16'd1);
    vecs[10] = mk(0, 1, 4'b0000, 32'h0000_0000, 1, S_WB, 4'b0000, 4'b0001, 0, 8'h5A, 1, 1, 0, 16'd1);
    vecs[11] = mk(0, 1, 4'b0000, 32'h0000_0000, 1, S_I,  4'b0000, 4'b0000, 0, 8'h5A, 0, 0, 1, 16'd1);
    // Enable dropped during WAIT_DONE while requester 1 keeps requesting
    vecs[12] = mk(0, 1, 4'b0010, 32'h0000_3C00, 1, S_L,  4'b0010, 4'b0010, 1, 8'h3C, 1, 1, 1, 16'd1);
    vecs[13] = mk(0, 1, 4'b0010, 32'h0000_3C00, 0, S_WB, 4'b0000, 4'b0010, 0, 8'h3C, 1, 1, 1, 16'd1);
    vecs[14] = mk(0, 1, 4'b0010, 32'h0000_3C00, 0, S_WD, 4'b0000, 4'b0010, 0, 8'h3C, 1, 1, 1, 16'd1);
    vecs[15] = mk(0, 0, 4'b0010, 32'h0000_3C00, 0, S_WD, 4'b0000, 4'b0010, 0, 8'h3C, 1, 1, 1, 16'd1);
    vecs[16] = mk(0, 0, 4'b0010, 32'h0000_3C00, 1, S_G,  4'b0000, 4'b0000, 0, 8'h3C, 0, 1, 1, 16'd2);
    vecs[17] = mk(0, 0, 4'b0010, 32'h0000_3C00, 1, S_G,  4'b0000, 4'b0000, 0, 8'h3C, 0, 1, 1, 16'd2);
    vecs[18] = mk(0, 0, 4'b0010, 32'h0000_3C00, 1, S_I,  4'b0000, 4'b0000, 0, 8'h3C, 0, 0, 1, 16'd2);
    vecs[19] = mk(0, 0, 4'b0010, 32'h0000_3C00, 1, S_I,  4'b0000, 4'b0000, 0, 8'h3C, 0, 0, 1, 16'd2);
    vecs[20] = mk(0, 0, 4'b0010, 32'h0000_3C00, 1, S_I,  4'b0000, 4'b0000, 0, 8'h3C, 0, 0, 1, 16'd2);
    vecs[21] = mk(0, 1, 4'b0010, 32'h0000_3C00, 1, S_L,  4'b0010, 4'b0010, 1, 8'h3C, 1, 1, 1, 16'd2);
    // Reset in WAIT_DONE, then requester 1 wins over 3
    vecs[22] = mk(0, 1, 4'b0000, 32'h0000_0000, 0, S_WB, 4'b0000, 4'b0010, 0, 8'h3C, 1, 1, 1, 16'd2);
    vecs[23] = mk(0, 1, 4'b0000, 32'h0000_0000, 0, S_WD, 4'b0000, 4'b0010, 0, 8'h3C, 1, 1, 1, 16'd2);
    vecs[24] = mk(1, 1, 4'b0000, 32'h0000_0000, 0, S_I,  4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0, 16'd0);
    vecs[25] = mk(0, 1, 4'b1010, 32'hB000_C000, 1, S_L,  4'b0010, 4'b0010, 1, 8'hC0, 1, 1, 0, 16'd0);

    @(negedge Clock);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].data, vecs[i].empty);
      tick();
      chk("state",     i, 32'(Dbg_State),      32'(vecs[i].st));
      chk("ack",       i, 32'(bus.Ack),        32'(vecs[i].ack));
      chk("grant",     i, 32'(bus.Grant),      32'(vecs[i].grant));
      chk("ld_tx",     i, 32'(bus.ld_Tx_Data), 32'(vecs[i].ld));
      chk("tx_data",   i, 32'(bus.Tx_Data),    32'(vecs[i].txd));
      chk("tx_enable", i, 32'(bus.Tx_Enable),  32'(vecs[i].txen));
      chk("busy",      i, 32'(Busy),           32'(vecs[i].busy));
      chk("load_err",  i, 32'(Load_Err),       32'(vecs[i].lerr));
      chk("frames",    i, 32'(Frame_Count),    32'(vecs[i].fc));
    end

    // Round robin with all four requesting and a UART that drains each byte
    drive(1'b1, 1'b1, 4'b0000, 32'h4433_2211, 1'b1);
    tick();
    drive(1'b0, 1'b1, 4'b1111, 32'h4433_2211, 1'b1);
    for (int f = 0; f < 5; f++) begin
      exp_ack = 4'b0001 << (f % 4);
      exp_txd = 8'h11 * 8'((f % 4) + 1);
      n = 0;
      while (bus.ld_Tx_Data !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("rr_ld",  f, 32'(bus.ld_Tx_Data), 32'd1);
      chk("rr_ack", f, 32'(bus.Ack),        32'(exp_ack));
      chk("rr_txd", f, 32'(bus.Tx_Data),    32'(exp_txd));
      bus.Tx_Empty = 1'b0;
      tick();
      tick();
      tick();
      bus.Tx_Empty = 1'b1;
      n = 0;
      while (Busy !== 1'b0 && n < 20) begin
        tick();
        n++;
      end
      chk("rr_idle", f, 32'(Busy), 32'd0);
    end
    chk("rr_frames", 5, 32'(Frame_Count), 32'd5);
    chk("rr_load_err", 5, 32'(Load_Err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 2, SHALL set the idle Clock cycles inserted between consecutive frames (legal range 0..15).
REQ-002 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of Clock.
REQ-004 Enable  input  1  SHALL permit new grants when 1.
REQ-005 Req  input  4  SHALL carry one transmit request per requester; Req[i] stays high until Ack[i].
REQ-006 Req_Data  input  32  SHALL carry requester i's byte on bits [8i+7:8i], stable while Req[i]=1.
REQ-007 Ack  output  4  SHALL be a one-cycle, one-hot pulse accepting requester i's byte.
REQ-008 Grant  output  4  SHALL be one-hot, naming the current owner; 0 when no frame is in flight.
REQ-009 ld_Tx_Data  output  1  SHALL be the load strobe to the UART transmitter.
REQ-010 Tx_Data  output  8  SHALL be the byte presented to the UART transmitter.
REQ-011 Tx_Enable  output  1  SHALL be the UART transmitter enable.
REQ-012 Tx_Empty  input  1  SHALL be the UART transmitter's holding-register-empty flag.
REQ-013 Busy  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-014 Load_Err  output  1  SHALL be the sticky flag for a load the transmitter failed to take.
REQ-015 Frame_Count  output  16  SHALL count frames completed.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WAIT_BUSY, WAIT_DONE and GAP.
REQ-017 IDLE: if Enable=1, Tx_Empty=1 and any Req bit is set, the FSM SHALL perform the following on that edge:
  - pick a winner;
  - latch Req_Data for the winner into Tx_Data;
  - set the Grant bit for the winner;
  - go to LOAD.
  Otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin, with priority order Last+1, Last+2, Last+3, Last (mod 4); Last SHALL update to the winner on entry to LOAD.
REQ-019 LOAD lasts exactly 1 cycle; while in LOAD, ld_Tx_Data=1, Ack[winner]=1 and Tx_Enable=1, and the next state SHALL be WAIT_BUSY.
REQ-020 WAIT_BUSY, Tx_Empty=0: the FSM SHALL go to WAIT_DONE.
REQ-021 WAIT_BUSY, Tx_Empty=1 for 2 consecutive cycles: the FSM SHALL set Load_Err, clear Grant and go to IDLE.
REQ-022 WAIT_DONE: Tx_Empty=1 SHALL increment Frame_Count, clear Grant and go to GAP (or to IDLE if GAP_CYCLES=0).
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, counted by a 4-bit down-counter, then go to IDLE.
REQ-024 Tx_Enable SHALL be 1 in LOAD, WAIT_BUSY and WAIT_DONE, and 0 in IDLE and GAP.
REQ-025 Enable=0 SHALL block new grants only; a frame already past IDLE SHALL complete normally.
REQ-026 ld_Tx_Data, Ack, Grant, Tx_Enable and Busy SHALL be registered (direct state decode of flops), so there is no combinational path from Req or Tx_Empty to any output.
REQ-027 Tx_Data SHALL hold the latched byte from LOAD until the next grant.
REQ-028 Req changes outside IDLE SHALL be ignored; a requester SHALL receive at most one Ack per grant.
REQ-029 Frame_Count SHALL wrap from 0xFFFF to 0x0000.
REQ-030 Minimum Req-to-ld_Tx_Data latency SHALL be 1 cycle: Req sampled in IDLE at edge n gives ld_Tx_Data=1 in the cycle after edge n.

Reset
REQ-031 Reset=1 at an edge SHALL force all of the following, even mid-frame:
  - state IDLE, Last=3;
  - Ack=0, Grant=0, ld_Tx_Data=0, Tx_Enable=0;
  - Tx_Data=0x00, Busy=0, Load_Err=0;
  - Frame_Count=0x0000, GAP counter=0.
REQ-032 Reset SHALL take priority over every other input; the first grant after reset SHALL favour requester 0.

Verification
REQ-033 Single request: Req=4'b0100, Req_Data[23:16]=0xA5, Tx_Empty=1 -> next cycle ld_Tx_Data=1, Tx_Data=0xA5, Ack=4'b0100, Grant=4'b0100.
REQ-034 Round-robin: Req=4'b1111 held, responsive UART model -> Acks in the order 0,1,2,3,0; Frame_Count=5 after the fifth frame.
REQ-035 Gap timing: GAP_CYCLES=2, Tx_Empty rising in WAIT_DONE -> Busy=1 for exactly 2 more cycles, then IDLE.
REQ-036 Stuck UART: Tx_Empty held at 1 after LOAD -> Load_Err=1 after 2 WAIT_BUSY cycles, FSM back in IDLE.
REQ-037 Enable dropped mid-frame: Enable=0 during WAIT_DONE -> the frame completes and Frame_Count increments; pending Req gets no Ack until Enable=1.
REQ-038 Reset mid-frame: Reset=1 in WAIT_DONE -> all outputs take their REQ-031 values on the next cycle; the next Req=4'b1010 is granted to requester 1.
